// File: rtl/rf_read_sequencer_if.sv
// rf_read_sequencer_if: request, register-file port, write-back and response signals of the operand-read sequencer
interface rf_read_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              rf_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_rdata;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    modport master (
        output req_valid, rs1, rs2, rf_rdata, wb_en, wb_addr, wb_data, rsp_ready,
        input  req_ready, rf_en, rf_addr, rsp_valid, rs1_data, rs2_data
    );

    modport slave (
        input  req_valid, rs1, rs2, rf_rdata, wb_en, wb_addr, wb_data, rsp_ready,
        output req_ready, rf_en, rf_addr, rsp_valid, rs1_data, rs2_data
    );
endinterface

// File: rtl/rf_read_sequencer.sv
// rf_read_sequencer: reads two source operands through one register-file port, with write-back bypass
module rf_read_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic clk,
    input logic rst,
    rf_read_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD1, RD2, RESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic              rf_en_q;
    logic [ADDR_W-1:0] rf_addr_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rs1_d;
    logic [DATA_W-1:0] rs2_d;
    logic [DATA_W-1:0] rd_op;
    logic              hit1;
    logic              hit2;

    // rf_addr_q already holds the address being read, so the operand select keys off it
    assign rd_op = (rf_addr_q == '0) ? '0
                 : (bus.wb_en && bus.wb_addr == rf_addr_q) ? bus.wb_data
                 : bus.rf_rdata;
    assign hit1 = bus.wb_en && bus.wb_addr != '0 && bus.wb_addr == rs1_q;
    assign hit2 = bus.wb_en && bus.wb_addr != '0 && bus.wb_addr == rs2_q;

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rf_en     = rf_en_q;
    assign bus.rf_addr   = rf_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rs1_data  = rs1_d;
    assign bus.rs2_data  = rs2_d;

    // Sequencer: state, port drive and operand capture all registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rf_en_q     <= 1'b0;
            rf_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rs1_d       <= '0;
            rs2_d       <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    rs1_q     <= bus.rs1;
                    rs2_q     <= bus.rs2;
                    rf_en_q   <= 1'b1;
                    rf_addr_q <= bus.rs1;
                    state     <= RD1;
                end
                RD1: begin
                    rs1_d <= rd_op;
                    if (rs2_q == rs1_q) begin
                        rs2_d       <= rd_op;
                        rf_en_q     <= 1'b0;
                        rf_addr_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        rf_addr_q <= rs2_q;
                        state     <= RD2;
                    end
                end
                RD2: begin
                    rs2_d       <= rd_op;
                    rf_en_q     <= 1'b0;
                    rf_addr_q   <= '0;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (hit1) rs1_d <= bus.wb_data;
                    if (hit2) rs2_d <= bus.wb_data;
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
